// File: rtl/periph_arbiter_if.sv
// rtl/periph_arbiter_if.sv - request/peripheral bundle shared by the arbiter and its users
//
// Purpose: groups the four requester channels and the 4-phase peripheral
// handshake into one bundle.
// Ports (signals):
//   req[3:0]        requester levels, held until done/err
//   req_data[4*DW]  packed request words, requester i at [i*DW +: DW]
//   done[3:0]       one-cycle success pulse to the served requester
//   err[3:0]        one-cycle timeout pulse to the served requester
//   busy            arbiter not idle
//   grant_id[1:0]   requester being served, valid while busy
//   send            4-phase request to the peripheral
//   per_data[DW]    word presented to the peripheral, stable while busy
//   ack             4-phase acknowledge from the peripheral
// Modports: slave = arbiter side, master = requesters/peripheral side.
interface periph_arbiter_if #(
  parameter int DW = 8
);
  logic [3:0]      req;
  logic [4*DW-1:0] req_data;
  logic [3:0]      done;
  logic [3:0]      err;
  logic            busy;
  logic [1:0]      grant_id;
  logic            send;
  logic [DW-1:0]   per_data;
  logic            ack;

  modport slave (
    input  req, req_data, ack,
    output done, err, busy, grant_id, send, per_data
  );

  modport master (
    output req, req_data, ack,
    input  done, err, busy, grant_id, send, per_data
  );
endinterface

// File: rtl/periph_arbiter.sv
// rtl/periph_arbiter.sv - round-robin arbiter for a shared 4-phase peripheral
//
// Purpose: grants one of four requesters, forwards its word to the peripheral
// over a 4-phase send/ack handshake, and reports done or err (timeout) back.
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset
//   bus   periph_arbiter_if.slave (requests, peripheral handshake, status)
// All outputs are flops; nothing on req or ack reaches an output combinationally.
module periph_arbiter #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  periph_arbiter_if.slave       bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_REL  = 3'd2,
    S_FIN  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      timer_q, timer_d;
  logic [1:0]      last_id_q, last_id_d;
  logic [1:0]      grant_id_q, grant_id_d;
  logic [DW-1:0]   per_data_q, per_data_d;
  logic            send_q, send_d;
  logic            busy_q, busy_d;
  logic [3:0]      done_q, done_d;
  logic [3:0]      err_q, err_d;

  logic            pick_valid;
  logic [1:0]      pick_id;
  logic [1:0]      cand;

  // Round-robin search starting just after the last served requester.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = 2'd0;
    cand       = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = last_id_q + 2'(k + 1);
      if (!pick_valid && bus.req[cand]) begin
        pick_valid = 1'b1;
        pick_id    = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    last_id_d  = last_id_q;
    grant_id_d = grant_id_q;
    per_data_d = per_data_q;

    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          state_d    = S_REQ;
          grant_id_d = pick_id;
          per_data_d = bus.req_data[pick_id*DW +: DW];
          timer_d    = 8'd0;
        end
      end
      // Exit condition is tested before the timer so it wins a tie.
      S_REQ: begin
        if (bus.ack) begin
          state_d = S_REL;
          timer_d = 8'd0;
        end else if (timer_q == 8'(TIMEOUT - 1)) begin
          state_d   = S_ERR;
          last_id_d = grant_id_q;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_REL: begin
        if (!bus.ack) begin
          state_d   = S_FIN;
          last_id_d = grant_id_q;
        end else if (timer_q == 8'(TIMEOUT - 1)) begin
          state_d   = S_ERR;
          last_id_d = grant_id_q;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register with it.
    send_d = (state_d == S_REQ);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN) ? (4'b0001 << grant_id_d) : 4'b0000;
    err_d  = (state_d == S_ERR) ? (4'b0001 << grant_id_d) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= 8'd0;
      last_id_q  <= 2'd3;
      grant_id_q <= 2'd0;
      per_data_q <= '0;
      send_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 4'b0000;
      err_q      <= 4'b0000;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      last_id_q  <= last_id_d;
      grant_id_q <= grant_id_d;
      per_data_q <= per_data_d;
      send_q     <= send_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.send     = send_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.grant_id = grant_id_q;
  assign bus.per_data = per_data_q;

endmodule

// File: tb/tb_periph_arbiter.sv
// tb/tb_periph_arbiter.sv - scoreboard bench for periph_arbiter
module tb_periph_arbiter;

  logic clk;
  logic rst;

  periph_arbiter_if #(.DW(8)) bus ();

  periph_arbiter #(.DW(8), .TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] gid;
    logic [7:0] data;
    logic [3:0] done;
    logic [3:0] err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   per_mode = 0;  // 0: normal 2-edge peripheral, 1: ack tied 0, 2: ack stuck 1

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] g, input logic [7:0] d, input logic [3:0] dn, input logic [3:0] er);
    exp_t e;
    e.gid = g; e.data = d; e.done = dn; e.err = er;
    return e;
  endfunction

  // Peripheral: ack rises after seeing send on 3 consecutive edges, drops
  // after seeing send low on 2 consecutive edges.
  initial begin
    int hi, lo;
    hi = 0; lo = 0;
    bus.ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (per_mode == 1) begin
        bus.ack = 1'b0; hi = 0; lo = 0;
      end else if (bus.send) begin
        lo = 0;
        if (hi < 3) hi++;
        if (hi == 3) bus.ack = 1'b1;
      end else begin
        hi = 0;
        if (bus.ack && per_mode == 0) begin
          lo++;
          if (lo == 2) begin bus.ack = 1'b0; lo = 0; end
        end
      end
    end
  end

  // Monitor: every done/err pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst && (bus.done | bus.err) != 4'b0000) begin
      chk("pulse_onehot", $countones(bus.done | bus.err), 1);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {bus.done, bus.err}, 8'h00);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_done", bus.done, mon_e.done);
        chk("sb_err", bus.err, mon_e.err);
        chk("sb_grant_id", bus.grant_id, mon_e.gid);
        chk("sb_per_data", bus.per_data, mon_e.data);
      end
    end
  end

  // Waits for n pulses; optionally drops each served req bit; clears req at the end.
  task automatic wait_pulses(input int n, input int budget, input bit drop_each, output int send_cyc);
    int seen;
    seen = 0;
    send_cyc = 0;
    for (int c = 0; c < budget && seen < n; c++) begin
      @(negedge clk);
      if (bus.send) send_cyc++;
      if ((bus.done | bus.err) != 4'b0000) begin
        seen++;
        if (drop_each) bus.req = bus.req & ~(bus.done | bus.err);
      end
    end
    bus.req = 4'b0000;
    chk("pulse_count", seen, n);
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) @(negedge clk);
  endtask

  initial begin
    int send_cyc, done_cyc, busy_seen, waited;
    logic [7:0] send_mask;

    rst = 1'b1;
    bus.req = 4'b0000;
    bus.req_data = '0;
    idle_cycles(3);
    chk("rst_send", bus.send, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_grant_id", bus.grant_id, 0);
    chk("rst_per_data", bus.per_data, 0);
    rst = 1'b0;
    idle_cycles(2);

    // Single request, latency profile of the 2-edge peripheral.
    bus.req_data = 32'h11A5_3344;
    bus.req = 4'b0100;
    exp_q.push_back(mk(2'd2, 8'hA5, 4'b0100, 4'b0000));
    @(posedge clk);
    send_mask = 8'h00;
    done_cyc = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      send_mask[c] = bus.send;
      if (bus.done != 4'b0000) begin
        done_cyc = c;
        bus.req = 4'b0000;
      end
    end
    chk("lat_send_window", send_mask, 8'b0000_0111);
    chk("lat_done_cycle", done_cyc, 5);
    idle_cycles(3);

    // All four requesting after reset: 0,1,2,3,0.
    rst = 1'b1;
    idle_cycles(1);
    rst = 1'b0;
    bus.req_data = 32'h4433_2211;
    bus.req = 4'b1111;
    exp_q.push_back(mk(2'd0, 8'h11, 4'b0001, 4'b0000));
    exp_q.push_back(mk(2'd1, 8'h22, 4'b0010, 4'b0000));
    exp_q.push_back(mk(2'd2, 8'h33, 4'b0100, 4'b0000));
    exp_q.push_back(mk(2'd3, 8'h44, 4'b1000, 4'b0000));
    exp_q.push_back(mk(2'd0, 8'h11, 4'b0001, 4'b0000));
    wait_pulses(5, 100, 1'b0, send_cyc);
    idle_cycles(3);

    // ack tied low: REQ timeout.
    per_mode = 1;
    idle_cycles(2);
    bus.req_data = 32'h0000_5C00;
    bus.req = 4'b0010;
    exp_q.push_back(mk(2'd1, 8'h5C, 4'b0000, 4'b0010));
    wait_pulses(1, 40, 1'b1, send_cyc);
    chk("req_timeout_send_cycles", send_cyc, 15);
    @(negedge clk);
    chk("req_timeout_busy_after", bus.busy, 0);
    per_mode = 0;
    idle_cycles(3);

    // ack stuck high: REL timeout.
    per_mode = 2;
    bus.req_data = 32'h3C00_0000;
    bus.req = 4'b1000;
    exp_q.push_back(mk(2'd3, 8'h3C, 4'b0000, 4'b1000));
    wait_pulses(1, 40, 1'b1, send_cyc);
    chk("rel_timeout_send_cycles", send_cyc, 3);
    per_mode = 0;
    idle_cycles(5);

    // Reset during REQ; afterwards requester 0 beats requester 3.
    bus.req_data = 32'h0000_6600;
    bus.req = 4'b0010;
    exp_q.push_back(mk(2'd1, 8'h66, 4'b0010, 4'b0000));
    wait_pulses(1, 20, 1'b1, send_cyc);
    idle_cycles(2);
    bus.req_data = 32'hD000_BBCC;
    bus.req = 4'b0100;
    waited = 0;
    while (!bus.send && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk("rst_mid_send_seen", bus.send, 1);
    rst = 1'b1;
    bus.req = 4'b0000;
    @(negedge clk);
    chk("rst_mid_send", bus.send, 0);
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_done_err", {bus.done, bus.err}, 0);
    rst = 1'b0;
    idle_cycles(3);
    bus.req_data = 32'hD000_00CC;
    bus.req = 4'b1001;
    exp_q.push_back(mk(2'd0, 8'hCC, 4'b0001, 4'b0000));
    exp_q.push_back(mk(2'd3, 8'hD0, 4'b1000, 4'b0000));
    wait_pulses(2, 40, 1'b1, send_cyc);
    idle_cycles(3);

    // req[3] dropped during REL: completes, not re-granted.
    bus.req_data = 32'h7700_0000;
    bus.req = 4'b1000;
    exp_q.push_back(mk(2'd3, 8'h77, 4'b1000, 4'b0000));
    waited = 0;
    while (!bus.send && waited < 10) begin @(negedge clk); waited++; end
    while (bus.send && waited < 20) begin @(negedge clk); waited++; end
    chk("drop_in_rel_busy", bus.busy, 1);
    bus.req = 4'b0000;
    wait_pulses(1, 20, 1'b1, send_cyc);
    busy_seen = 0;
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.busy) busy_seen++;
    end
    chk("no_regrant", busy_seen, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/periph_arbiter.md
PERIPH_ARBITER -- requirements
Module: periph_arbiter

Parameters
REQ-001 DW, 8, width of data word delivered to the peripheral.
REQ-002 TIMEOUT, 15, max cycles spent in REQ or REL before abort (legal range 2..255).

Interface
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  4  per-requester transfer request, level; held until done/err.
REQ-006 req_data  input  4*DW  packed request words, requester i at bits [i*DW +: DW].
REQ-007 done  output  4  one-cycle pulse to the served requester on successful handshake.
REQ-008 err  output  4  one-cycle pulse to the served requester on timeout.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 grant_id  output  2  index of requester currently served; valid while busy.
REQ-011 send  output  1  4-phase request to the shared peripheral.
REQ-012 per_data  output  DW  word presented to the peripheral; stable while busy.
REQ-013 ack  input  1  4-phase acknowledge from the peripheral.

Function
REQ-014 FSM states: IDLE, REQ, REL, FIN, ERR; all outputs registered/Moore, no combinational path from req or ack to any output.
REQ-015 IDLE: send=0; if any req bit high at an edge, grant one requester, latch grant_id and its req_data into per_data, enter REQ.
REQ-016 Arbitration is round-robin: priority order starts at last_id+1 and wraps modulo 4; last_id updates only on entry to FIN or ERR.
REQ-017 REQ: send=1; on ack=1 at an edge go to REL.
REQ-018 REL: send=0; on ack=0 at an edge go to FIN.
REQ-019 FIN: done[grant_id]=1 for exactly one cycle, then IDLE.
REQ-020 ERR: err[grant_id]=1 for exactly one cycle, send=0, then IDLE.
REQ-021 4-bit/8-bit timer cleared on entry to REQ and REL, increments each cycle there; when TIMEOUT cycles elapse in the state without the exit condition, go to ERR.
REQ-022 Exit condition and timeout expiring on the same edge: exit condition wins.
REQ-023 ack ignored in IDLE, FIN, ERR; an ack already high on entry to REQ is accepted next edge.
REQ-024 req deasserting mid-transaction is ignored; the transaction completes or times out normally.
REQ-025 Back-to-back: earliest next grant is the edge at which FIN/ERR returns to IDLE+1 (one IDLE cycle minimum between transactions).
REQ-026 Latency with a peripheral raising ack 2 edges after send and dropping it 1 edge after send falls: req sampled at E0 -> send high after E0, low after E3, done pulse after E5.
REQ-027 done and err never both set; at most one bit of done|err high per cycle.

Reset
REQ-028 On rst at an edge: state IDLE, send=0, busy=0, done=0, err=0, grant_id=0, per_data=0, timer=0, last_id=3 (requester 0 highest priority).
REQ-029 rst mid-transaction aborts with no done/err pulse; send low the cycle after the reset edge.

Verification
REQ-030 Single req[2]=1, data 0xA5, 2-cycle-ack peripheral -> per_data=0xA5, grant_id=2, send high E0..E3, done=4'b0100 one cycle after E5.
REQ-031 req=4'b1111 held after reset -> grants in order 0,1,2,3,0, each followed by its done pulse.
REQ-032 ack tied 0, req[1]=1 -> send high 15 cycles, then err=4'b0010 one cycle, no done, busy low after.
REQ-033 ack rises then stuck 1 -> REL times out after 15 cycles, err pulse to grantee, send stays 0.
REQ-034 rst asserted during REQ -> next cycle send=0, busy=0, no done/err; next grant goes to requester 0.
REQ-035 req[3] dropped while in REL -> transaction completes, done[3] pulses, req[3] not re-granted.
